// File: rtl/pfpu_rsqrt_nr_if.sv
// Operand/result bundle for the reciprocal-square-root Newton-Raphson stage.
// The master supplies a/y0/valid_i; the slave returns r/valid_o/busy.
interface pfpu_rsqrt_nr_if;
   logic [31:0] a;
   logic [31:0] y0;
   logic        valid_i;
   logic [31:0] r;
   logic        valid_o;
   logic        busy;

   modport master (output a, y0, valid_i, input r, valid_o, busy);
   modport slave  (input a, y0, valid_i, output r, valid_o, busy);
endinterface

// File: rtl/pfpu_rsqrt_nr.sv
// Iterative Newton-Raphson refinement of 1/sqrt(|a|): y <- y*(1.5 - 0.5*a*y*y),
// sequenced over SQ/MA/SUB/MY with a single shared 24x24 mantissa multiplier.
module pfpu_rsqrt_nr #(
   parameter int ITERATIONS = 1
) (
   input  logic           sys_clk,
   input  logic           alu_rst_n,
   pfpu_rsqrt_nr_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SQ   = 3'd1,
      MA   = 3'd2,
      SUB  = 3'd3,
      MY   = 3'd4,
      DONE = 3'd5
   } state_t;

   state_t      state_r, state_next_s;
   logic [31:0] a_r, y_r, t_r, d_r, r_r;
   logic [1:0]  cnt_r;
   logic        zero_a_r, valid_o_r, busy_r, last_s;
   logic [31:0] mul_x_s, mul_y_s, mul_p_s, sub_s;

   // Truncating float multiply; exponent underflow flushes to +0, overflow saturates.
   function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
      logic [47:0] prod_s;
      logic [9:0]  ex_s;
      logic [22:0] man_s;
      logic [31:0] res_s;
      prod_s = {1'b1, x[22:0]} * {1'b1, y[22:0]};
      ex_s   = {2'b00, x[30:23]} + {2'b00, y[30:23]} - 10'd127;
      if (prod_s[47]) begin
         man_s = 23'(prod_s >> 24);
         ex_s  = ex_s + 10'd1;
      end else begin
         man_s = 23'(prod_s >> 23);
      end
      if ((x[30:23] == 8'd0) || (y[30:23] == 8'd0)) res_s = 32'h0000_0000;
      else if (ex_s[9] || (ex_s == 10'd0))           res_s = 32'h0000_0000;
      else if (ex_s >= 10'd255)                      res_s = 32'h7F7F_FFFF;
      else                                           res_s = {x[31] ^ y[31], ex_s[7:0], man_s};
      return res_s;
   endfunction

   function automatic logic [31:0] fhalf(input logic [31:0] x);
      logic [31:0] res_s;
      if (x[30:23] <= 8'd1) res_s = 32'h0000_0000;
      else                  res_s = {x[31], x[30:23] - 8'd1, x[22:0]};
      return res_s;
   endfunction

   // 1.5 - t evaluated in a 2.24 fixed-point frame, then renormalised (truncating).
   function automatic logic [31:0] fsub15(input logic [31:0] t);
      logic [25:0] t_fx_s, d_fx_s, norm_s;
      logic [7:0]  sh_s;
      logic [4:0]  lead_s;
      logic [31:0] res_s;
      if (t[30:23] < 8'd104) begin
         res_s = 32'h3FC0_0000;
      end else if (t >= 32'h3FC0_0000) begin
         res_s = 32'h0000_0000;
      end else begin
         sh_s   = 8'd127 - t[30:23];
         t_fx_s = {1'b0, 1'b1, t[22:0], 1'b0} >> sh_s;
         d_fx_s = 26'h180_0000 - t_fx_s;
         lead_s = 5'd0;
         for (int i = 32'sd0; i < 32'sd26; i++) begin
            lead_s = d_fx_s[i] ? 5'(i) : lead_s;
         end
         norm_s = d_fx_s << (5'd25 - lead_s);
         res_s  = {1'b0, 8'd103 + {3'b000, lead_s}, 23'(norm_s >> 2)};
      end
      return res_s;
   endfunction

   assign last_s = (cnt_r == 2'(ITERATIONS - 32'sd1));

   // Operand steering for the shared multiplier
   always_comb begin
      mul_x_s = y_r;
      mul_y_s = y_r;
      case (state_r)
         SQ: begin
            mul_x_s = y_r;
            mul_y_s = y_r;
         end
         MA: begin
            mul_x_s = t_r;
            mul_y_s = a_r;
         end
         MY: begin
            mul_x_s = y_r;
            mul_y_s = d_r;
         end
         default: begin
            mul_x_s = y_r;
            mul_y_s = y_r;
         end
      endcase
      mul_p_s = fmul(mul_x_s, mul_y_s);
      sub_s   = fsub15(t_r);
   end

   // Next-state sequencing
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.valid_i) state_next_s = SQ;
            else             state_next_s = IDLE;
         end
         SQ:  state_next_s = MA;
         MA:  state_next_s = SUB;
         SUB: state_next_s = MY;
         MY: begin
            if (last_s) state_next_s = DONE;
            else        state_next_s = SQ;
         end
         DONE:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // State register plus registered handshake outputs
   always_ff @(posedge sys_clk) begin
      if (!alu_rst_n) begin
         state_r   <= IDLE;
         valid_o_r <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_next_s;
         valid_o_r <= (state_next_s == DONE);
         busy_r    <= (state_next_s != IDLE);
      end
   end

   // Datapath registers
   always_ff @(posedge sys_clk) begin
      if (!alu_rst_n) begin
         a_r      <= 32'h0000_0000;
         y_r      <= 32'h0000_0000;
         t_r      <= 32'h0000_0000;
         d_r      <= 32'h0000_0000;
         r_r      <= 32'h0000_0000;
         cnt_r    <= 2'd0;
         zero_a_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.valid_i) begin
                  a_r      <= bus.a & 32'h7FFF_FFFF;
                  y_r      <= bus.y0;
                  cnt_r    <= 2'd0;
                  zero_a_r <= (bus.a[30:23] == 8'd0);
               end
            end
            SQ:  t_r <= mul_p_s;
            MA:  t_r <= fhalf(mul_p_s);
            SUB: d_r <= sub_s;
            MY: begin
               y_r   <= mul_p_s;
               cnt_r <= cnt_r + 2'd1;
               if (last_s) r_r <= zero_a_r ? 32'h7F7F_FFFF : mul_p_s;
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   assign bus.r       = r_r;
   assign bus.valid_o = valid_o_r;
   assign bus.busy    = busy_r;

endmodule
